// File: rtl/lcd_pkg.sv
// rtl/lcd_pkg.sv - shared constants and state encoding for the KS0108 left-half panel driver
package lcd_pkg;

    localparam logic [7:0] DISP_ON    = 8'h3F;
    localparam logic [7:0] START_LINE = 8'hC0;
    localparam logic [7:0] SET_PAGE   = 8'hB8;
    localparam logic [7:0] SET_Y      = 8'h40;
    localparam logic [1:0] CS_LEFT    = 2'b01;

    typedef enum logic [3:0] {
        ST_RST_HOLD,
        ST_RST_WAIT,
        ST_CMD_ON,
        ST_CMD_START,
        ST_CMD_PAGE,
        ST_CMD_COL,
        ST_REQ,
        ST_WAIT,
        ST_WR_DATA
    } state_t;

    function automatic logic [7:0] page_cmd(input logic [2:0] page);
        return SET_PAGE | {5'b00000, page};
    endfunction

endpackage

// File: rtl/lcd_bus_writer.sv
// rtl/lcd_bus_writer.sv - one panel bus write: setup, enable pulse, hold
module lcd_bus_writer #(
    parameter int SETUP_CYC = 2,
    parameter int PULSE_CYC = 4,
    parameter int HOLD_CYC  = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start_i,
    input  logic       di_i,
    input  logic [7:0] byte_i,
    output logic       done_o,
    output logic       lcd_e_o,
    output logic       lcd_di_o,
    output logic [7:0] lcd_data_o
);

    localparam logic [7:0] E_ON  = 8'(SETUP_CYC);
    localparam logic [7:0] E_OFF = 8'(SETUP_CYC + PULSE_CYC);
    localparam logic [7:0] LAST  = 8'(SETUP_CYC + PULSE_CYC + HOLD_CYC - 1);

    logic       busy_q;
    logic [7:0] cnt_q;
    logic [7:0] cnt_d;
    logic       e_q;
    logic       di_q;
    logic [7:0] data_q;

    assign cnt_d      = cnt_q + 8'd1;
    assign done_o     = busy_q && (cnt_q == LAST);
    assign lcd_e_o    = e_q;
    assign lcd_di_o   = di_q;
    assign lcd_data_o = data_q;

    // Bus value is latched at start and held until the next start, so it stays put through hold.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q <= 1'b0;
            cnt_q  <= 8'd0;
            e_q    <= 1'b0;
            di_q   <= 1'b0;
            data_q <= 8'h00;
        end else if (start_i) begin
            busy_q <= 1'b1;
            cnt_q  <= 8'd0;
            e_q    <= 1'b0;
            di_q   <= di_i;
            data_q <= byte_i;
        end else if (busy_q) begin
            if (done_o) begin
                busy_q <= 1'b0;
                cnt_q  <= 8'd0;
                e_q    <= 1'b0;
            end else begin
                cnt_q <= cnt_d;
                e_q   <= (cnt_d >= E_ON) && (cnt_d < E_OFF);
            end
        end
    end

endmodule

// File: rtl/lcd_ctrl.sv
// rtl/lcd_ctrl.sv - panel init and page/column sequencer pulling bytes via en/data_valid
module lcd_ctrl
    import lcd_pkg::*;
#(
    parameter int SETUP_CYC = 2,
    parameter int PULSE_CYC = 4,
    parameter int HOLD_CYC  = 2,
    parameter int RST_CYC   = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] data_in,
    input  logic       data_valid,
    output logic       en,
    output logic       lcd_rst,
    output logic [1:0] lcd_cs,
    output logic       lcd_rw,
    output logic       lcd_di,
    output logic       lcd_e,
    output logic [7:0] lcd_data
);

    localparam logic [15:0] RST_LAST = 16'(RST_CYC - 1);

    state_t      state_q;
    logic [15:0] tmr_q;
    logic [8:0]  cnt_q;
    logic        issued_q;
    logic        en_q;
    logic        lcd_rst_q;
    logic [1:0]  cs_q;
    logic        start_d;
    logic        di_d;
    logic [7:0]  byte_d;
    logic        wr_done;

    assign en      = en_q;
    assign lcd_rst = lcd_rst_q;
    assign lcd_cs  = cs_q;
    assign lcd_rw  = 1'b0;

    // Start is combinational so a data byte reaches the bus two cycles after en.
    always_comb begin
        start_d = 1'b0;
        di_d    = 1'b0;
        byte_d  = 8'h00;
        case (state_q)
            ST_CMD_ON:    begin start_d = !issued_q; byte_d = DISP_ON;            end
            ST_CMD_START: begin start_d = !issued_q; byte_d = START_LINE;         end
            ST_CMD_PAGE:  begin start_d = !issued_q; byte_d = page_cmd(cnt_q[8:6]); end
            ST_CMD_COL:   begin start_d = !issued_q; byte_d = SET_Y;              end
            ST_WAIT:      begin start_d = data_valid; di_d = 1'b1; byte_d = data_in; end
            default:      ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_RST_HOLD;
            tmr_q     <= 16'd0;
            cnt_q     <= 9'd0;
            issued_q  <= 1'b0;
            en_q      <= 1'b0;
            lcd_rst_q <= 1'b0;
            cs_q      <= 2'b00;
        end else begin
            en_q <= 1'b0;
            if (start_d) issued_q <= 1'b1;
            else if (wr_done) issued_q <= 1'b0;
            case (state_q)
                ST_RST_HOLD: begin
                    if (tmr_q == RST_LAST) begin
                        tmr_q     <= 16'd0;
                        lcd_rst_q <= 1'b1;
                        cs_q      <= CS_LEFT;
                        state_q   <= ST_RST_WAIT;
                    end else begin
                        tmr_q <= tmr_q + 16'd1;
                    end
                end
                ST_RST_WAIT: begin
                    if (tmr_q == RST_LAST) begin
                        tmr_q   <= 16'd0;
                        state_q <= ST_CMD_ON;
                    end else begin
                        tmr_q <= tmr_q + 16'd1;
                    end
                end
                ST_CMD_ON:    if (wr_done) state_q <= ST_CMD_START;
                ST_CMD_START: if (wr_done) state_q <= ST_CMD_PAGE;
                ST_CMD_PAGE:  if (wr_done) state_q <= ST_CMD_COL;
                ST_CMD_COL: begin
                    if (wr_done) begin
                        state_q <= ST_REQ;
                        en_q    <= 1'b1;
                    end
                end
                ST_REQ: state_q <= ST_WAIT;
                ST_WAIT: begin
                    if (data_valid) begin
                        state_q <= ST_WR_DATA;
                    end else begin
                        state_q <= ST_REQ;
                        en_q    <= 1'b1;
                    end
                end
                ST_WR_DATA: begin
                    if (wr_done) begin
                        cnt_q <= cnt_q + 9'd1;
                        if (cnt_q[5:0] == 6'd63) begin
                            state_q <= ST_CMD_PAGE;
                        end else begin
                            state_q <= ST_REQ;
                            en_q    <= 1'b1;
                        end
                    end
                end
                default: state_q <= ST_RST_HOLD;
            endcase
        end
    end

    lcd_bus_writer #(
        .SETUP_CYC (SETUP_CYC),
        .PULSE_CYC (PULSE_CYC),
        .HOLD_CYC  (HOLD_CYC)
    ) u_writer (
        .clk        (clk),
        .rst        (rst),
        .start_i    (start_d),
        .di_i       (di_d),
        .byte_i     (byte_d),
        .done_o     (wr_done),
        .lcd_e_o    (lcd_e),
        .lcd_di_o   (lcd_di),
        .lcd_data_o (lcd_data)
    );

endmodule

// File: tb/tb_lcd_ctrl.sv
// tb/tb_lcd_ctrl.sv - scoreboard bench for lcd_ctrl: init, data, retry, page/frame wrap, reset
module tb_lcd_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] data_in = 8'h00;
    logic       data_valid = 1'b0;
    logic       en;
    logic       lcd_rst;
    logic [1:0] lcd_cs;
    logic       lcd_rw;
    logic       lcd_di;
    logic       lcd_e;
    logic [7:0] lcd_data;

    int         compared = 0;
    int         mismatched = 0;
    logic [8:0] exp_q[$];
    int         cyc = 0;
    int         nbytes = 0;
    int         skip_n = 0;
    bit         answer = 0;
    bit         pending = 0;
    bit         prev_en = 0;
    bit         prev_e = 0;
    bit         gap_on = 0;
    bit         last_answered = 0;
    bit         chk_next = 0;
    int         e_len = 0;
    int         last_en = 0;
    int         wr_start = -1;
    logic [7:0] last_byte = 8'h00;
    logic [8:0] e_bus = 9'h000;
    int         n;

    always #5 clk = ~clk;

    lcd_ctrl #(
        .SETUP_CYC (2),
        .PULSE_CYC (4),
        .HOLD_CYC  (2),
        .RST_CYC   (16)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .data_in    (data_in),
        .data_valid (data_valid),
        .en         (en),
        .lcd_rst    (lcd_rst),
        .lcd_cs     (lcd_cs),
        .lcd_rw     (lcd_rw),
        .lcd_di     (lcd_di),
        .lcd_e      (lcd_e),
        .lcd_data   (lcd_data)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] byte_of(input int k);
        logic [31:0] t;
        t = k * 3;
        return 8'hA5 ^ t[7:0];
    endfunction

    task automatic push_init();
        exp_q.push_back({1'b0, 8'h3F});
        exp_q.push_back({1'b0, 8'hC0});
        exp_q.push_back({1'b0, 8'hB8});
        exp_q.push_back({1'b0, 8'h40});
    endtask

    // One clock: sample at the falling edge, score bus writes, play the RAM controller.
    task automatic tick();
        logic [8:0] exp;
        logic [7:0] pg;
        @(negedge clk);
        cyc++;
        if (chk_next) begin
            check("data_on_bus_next_cycle", {lcd_di, lcd_data}, {1'b1, last_byte});
            check("e_low_at_write_start", lcd_e, 1'b0);
            chk_next = 0;
            wr_start = cyc;
        end
        if (lcd_e === 1'b1) begin
            if (prev_e) begin
                check("bus_stable_while_e", {lcd_di, lcd_data}, e_bus);
            end else begin
                e_len = 0;
                e_bus = {lcd_di, lcd_data};
                if (wr_start >= 0) begin
                    check("setup_cycles", cyc - wr_start, 2);
                    wr_start = -1;
                end
            end
            e_len++;
        end else if (prev_e) begin
            check("e_pulse_len", e_len, 4);
            check("write_expected", exp_q.size() != 0, 1'b1);
            if (exp_q.size() != 0) begin
                exp = exp_q.pop_front();
                check("bus_write", {lcd_di, lcd_data}, exp);
            end
        end
        data_valid = 1'b0;
        if (pending) begin
            pending    = 0;
            data_valid = 1'b1;
            data_in    = byte_of(nbytes);
            last_byte  = data_in;
            exp_q.push_back({1'b1, data_in});
            chk_next   = 1;
            nbytes++;
            if (nbytes % 64 == 0) begin
                pg = 8'((nbytes / 64) % 8);
                exp_q.push_back({1'b0, 8'hB8 | pg});
                exp_q.push_back({1'b0, 8'h40});
            end
        end
        if (en === 1'b1) begin
            check("en_single_cycle", prev_en, 1'b0);
            if (gap_on && !(last_answered && (nbytes % 64 == 0)))
                check("en_spacing", cyc - last_en, last_answered ? 10 : 2);
            gap_on  = 1;
            last_en = cyc;
            if (answer && skip_n == 0) begin
                pending       = 1;
                last_answered = 1;
            end else begin
                if (skip_n > 0) skip_n--;
                last_answered = 0;
                check("retry_no_strobe", lcd_e, 1'b0);
            end
        end
        prev_en = en;
        prev_e  = lcd_e;
    endtask

    initial begin
        repeat (3) tick();
        check("rst_en", en, 1'b0);
        check("rst_lcd_rst", lcd_rst, 1'b0);
        check("rst_lcd_cs", lcd_cs, 2'b00);
        check("rst_lcd_rw", lcd_rw, 1'b0);
        check("rst_lcd_di", lcd_di, 1'b0);
        check("rst_lcd_e", lcd_e, 1'b0);
        check("rst_lcd_data", lcd_data, 8'h00);

        push_init();
        answer = 1;
        rst = 1'b0;
        n = 0;
        while (lcd_rst === 1'b0 && n < 100) begin tick(); n++; end
        check("lcd_rst_low_cycles", n, 16);
        check("cs_left_after_reset", lcd_cs, 2'b01);

        n = 0;
        while (nbytes < 5 && n < 500) begin tick(); n++; end
        check("first_bytes_reached", nbytes >= 5, 1'b1);
        skip_n = 3;

        n = 0;
        while (!(nbytes >= 512 && exp_q.size() == 0) && n < 20000) begin tick(); n++; end
        answer = 0;
        check("frame_bytes", nbytes, 512);
        check("frame_queue_drained", exp_q.size(), 0);
        check("lcd_rw_low", lcd_rw, 1'b0);

        answer = 1;
        repeat (5) tick();
        n = 0;
        while (lcd_e !== 1'b1 && n < 200) begin tick(); n++; end
        check("found_e_high", lcd_e, 1'b1);
        #2 rst = 1'b1;
        #1;
        check("async_rst_e", lcd_e, 1'b0);
        check("async_rst_en", en, 1'b0);
        check("async_rst_lcd_rst", lcd_rst, 1'b0);
        check("async_rst_cs", lcd_cs, 2'b00);
        check("async_rst_data", lcd_data, 8'h00);
        exp_q.delete();
        pending = 0; chk_next = 0; wr_start = -1; gap_on = 0;
        answer = 0; data_valid = 1'b0; prev_e = 0; prev_en = 0;
        repeat (2) tick();
        push_init();
        rst = 1'b0;
        n = 0;
        while (lcd_rst === 1'b0 && n < 100) begin tick(); n++; end
        check("restart_lcd_rst_low_cycles", n, 16);
        n = 0;
        while (exp_q.size() != 0 && n < 300) begin tick(); n++; end
        check("restart_init_drained", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
